// File: rtl/ahb_ap_arbiter.sv
// ahb_ap_arbiter
// Shares the single AFT bus-master port between the CPU data requester and
// the JTAG debug access point. The grant is held across locked multi-beat
// sequences. A starvation counter forces a debug grant after STARVE_LIMIT
// consecutive CPU completions while debug is waiting.
//
// Ports
//   AFT_CLK, TRST          clock (rising edge), async active-low reset
//   cpu_* / dbg_*          requester side: ren/wen/addr/wdata/byte_en/lock in,
//                          busy/rdata out
//   ren, wen, addr, wdata, byte_en   downstream request (out)
//   busy, rdata            downstream completion status / read data (in)
//   grant_cpu, grant_dbg   decoded registered grant state
//
// state   | meaning
// IDLE    | no grant; downstream request lines driven to 0
// GNT_CPU | CPU owns the downstream port
// GNT_DBG | debug access point owns the downstream port

module ahb_ap_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        AFT_CLK,
   input  logic        TRST,
   input  logic        cpu_ren,
   input  logic        cpu_wen,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_byte_en,
   input  logic        cpu_lock,
   output logic        cpu_busy,
   output logic [31:0] cpu_rdata,
   input  logic        dbg_ren,
   input  logic        dbg_wen,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   input  logic [3:0]  dbg_byte_en,
   input  logic        dbg_lock,
   output logic        dbg_busy,
   output logic [31:0] dbg_rdata,
   output logic        ren,
   output logic        wen,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   output logic [3:0]  byte_en,
   input  logic        busy,
   input  logic [31:0] rdata,
   output logic        grant_cpu,
   output logic        grant_dbg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_CPU = 2'd1,
      GNT_DBG = 2'd2
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state, state_nxt;
   logic [3:0] starve_cnt, starve_nxt, starve_inc;
   logic       req_cpu, req_dbg;
   logic       cpu_done, dbg_done;

   assign req_cpu  = cpu_ren | cpu_wen;
   assign req_dbg  = dbg_ren | dbg_wen;
   assign cpu_done = (state == GNT_CPU) & req_cpu & ~busy;
   assign dbg_done = (state == GNT_DBG) & req_dbg & ~busy;

   // Saturating count value this completion would produce; the lock check
   // below looks at it so a lock cannot extend past the limit.
   assign starve_inc = (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;

   always_ff @(posedge AFT_CLK or negedge TRST) begin
      if (!TRST) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_cpu && req_dbg)
               state_nxt = (starve_cnt >= LIMIT) ? GNT_DBG : GNT_CPU;
            else if (req_cpu)
               state_nxt = GNT_CPU;
            else if (req_dbg)
               state_nxt = GNT_DBG;
         end
         GNT_CPU: begin
            if (!req_cpu)
               state_nxt = IDLE;
            else if (cpu_done) begin
               if (cpu_lock && !(req_dbg && (starve_inc >= LIMIT)))
                  state_nxt = GNT_CPU;
               else
                  state_nxt = IDLE;
            end
         end
         GNT_DBG: begin
            if (!req_dbg)
               state_nxt = IDLE;
            else if (dbg_done)
               state_nxt = dbg_lock ? GNT_DBG : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      starve_nxt = starve_cnt;
      if (!req_dbg)
         starve_nxt = 4'd0;
      else if ((state_nxt == GNT_DBG) && (state != GNT_DBG))
         starve_nxt = 4'd0;
      else if (cpu_done)
         starve_nxt = starve_inc;
   end

   // Downstream mux; a simultaneous ren+wen is forwarded as a write.
   always_comb begin
      ren     = 1'b0;
      wen     = 1'b0;
      addr    = 32'd0;
      wdata   = 32'd0;
      byte_en = 4'd0;
      case (state)
         GNT_CPU: begin
            wen     = cpu_wen;
            ren     = cpu_ren & ~cpu_wen;
            addr    = cpu_addr;
            wdata   = cpu_wdata;
            byte_en = cpu_byte_en;
         end
         GNT_DBG: begin
            wen     = dbg_wen;
            ren     = dbg_ren & ~dbg_wen;
            addr    = dbg_addr;
            wdata   = dbg_wdata;
            byte_en = dbg_byte_en;
         end
         default: ;
      endcase
   end

   assign grant_cpu = (state == GNT_CPU);
   assign grant_dbg = (state == GNT_DBG);
   assign cpu_busy  = req_cpu & ~(grant_cpu & ~busy);
   assign dbg_busy  = req_dbg & ~(grant_dbg & ~busy);
   assign cpu_rdata = grant_cpu ? rdata : 32'd0;
   assign dbg_rdata = grant_dbg ? rdata : 32'd0;

endmodule

// File: tb/tb_ahb_ap_arbiter.sv
module tb_ahb_ap_arbiter;

   logic        AFT_CLK = 1'b0;
   logic        TRST;
   logic        cpu_ren, cpu_wen, cpu_lock, cpu_busy;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic [3:0]  cpu_byte_en;
   logic        dbg_ren, dbg_wen, dbg_lock, dbg_busy;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic [3:0]  dbg_byte_en;
   logic        ren, wen, busy, grant_cpu, grant_dbg;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  byte_en;

   int checks = 0;
   int failures = 0;

   ahb_ap_arbiter #(.STARVE_LIMIT(4)) dut (
      .AFT_CLK(AFT_CLK), .TRST(TRST),
      .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_byte_en(cpu_byte_en), .cpu_lock(cpu_lock),
      .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata),
      .dbg_ren(dbg_ren), .dbg_wen(dbg_wen), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_byte_en(dbg_byte_en), .dbg_lock(dbg_lock),
      .dbg_busy(dbg_busy), .dbg_rdata(dbg_rdata),
      .ren(ren), .wen(wen), .addr(addr), .wdata(wdata), .byte_en(byte_en),
      .busy(busy), .rdata(rdata),
      .grant_cpu(grant_cpu), .grant_dbg(grant_dbg)
   );

   always #5 AFT_CLK = ~AFT_CLK;

   task automatic tick();
      @(posedge AFT_CLK);
      #1;
   endtask

   task automatic clear_inputs();
      cpu_ren = 0; cpu_wen = 0; cpu_lock = 0; cpu_addr = 0; cpu_wdata = 0; cpu_byte_en = 0;
      dbg_ren = 0; dbg_wen = 0; dbg_lock = 0; dbg_addr = 0; dbg_wdata = 0; dbg_byte_en = 0;
      busy = 0; rdata = 0;
   endtask

   task automatic test_reset();
      TRST = 1'b0;
      clear_inputs();
      #7;
      checks++; if (ren !== 1'b0 || wen !== 1'b0) begin failures++; $display("FAIL reset_req ren=%b wen=%b required 0/0", ren, wen); end
      checks++; if (grant_cpu !== 1'b0 || grant_dbg !== 1'b0) begin failures++; $display("FAIL reset_grant cpu=%b dbg=%b required 0/0", grant_cpu, grant_dbg); end
      checks++; if (addr !== 32'd0 || byte_en !== 4'd0) begin failures++; $display("FAIL reset_addr addr=%h be=%h required 0", addr, byte_en); end
      checks++; if (dut.starve_cnt !== 4'd0) begin failures++; $display("FAIL reset_starve got %0d required 0", dut.starve_cnt); end
      cpu_ren = 1; #1;
      checks++; if (cpu_busy !== 1'b1) begin failures++; $display("FAIL reset_busy_formula got %b required 1", cpu_busy); end
      cpu_ren = 0; #1;
      checks++; if (cpu_busy !== 1'b0) begin failures++; $display("FAIL reset_busy_noreq got %b required 0", cpu_busy); end
      tick();
      TRST = 1'b1;
      tick();
   endtask

   task automatic test_cpu_read();
      cpu_ren = 1; cpu_addr = 32'h1000_0040; cpu_byte_en = 4'hF; busy = 1; #1;
      checks++; if (ren !== 1'b0 || cpu_busy !== 1'b1) begin failures++; $display("FAIL rd_idle ren=%b cpu_busy=%b required 0/1", ren, cpu_busy); end
      tick();
      checks++; if (grant_cpu !== 1'b1 || ren !== 1'b1 || wen !== 1'b0) begin failures++; $display("FAIL rd_grant g=%b ren=%b wen=%b required 1/1/0", grant_cpu, ren, wen); end
      checks++; if (addr !== 32'h1000_0040 || byte_en !== 4'hF) begin failures++; $display("FAIL rd_addr addr=%h be=%h required 10000040/f", addr, byte_en); end
      checks++; if (cpu_busy !== 1'b1 || cpu_rdata !== 32'd0) begin failures++; $display("FAIL rd_wait busy=%b rdata=%h required 1/0", cpu_busy, cpu_rdata); end
      tick();
      checks++; if (grant_cpu !== 1'b1 || cpu_busy !== 1'b1) begin failures++; $display("FAIL rd_wait2 g=%b busy=%b required 1/1", grant_cpu, cpu_busy); end
      tick();
      busy = 0; rdata = 32'hDEAD_BEEF; #1;
      checks++; if (cpu_busy !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_done busy=%b rdata=%h required 0/deadbeef", cpu_busy, cpu_rdata); end
      tick();
      checks++; if (grant_cpu !== 1'b0 || ren !== 1'b0 || cpu_rdata !== 32'd0) begin failures++; $display("FAIL rd_idle_after g=%b ren=%b rdata=%h required 0/0/0", grant_cpu, ren, cpu_rdata); end
      clear_inputs();
      tick();
   endtask

   task automatic test_simultaneous();
      cpu_ren = 1; cpu_addr = 32'h2000_0000;
      dbg_wen = 1; dbg_addr = 32'h0000_0100; dbg_wdata = 32'h1234_5678; dbg_byte_en = 4'h3;
      busy = 1;
      tick();
      checks++; if (grant_cpu !== 1'b1 || grant_dbg !== 1'b0) begin failures++; $display("FAIL sim_first cpu=%b dbg=%b required 1/0", grant_cpu, grant_dbg); end
      checks++; if (dbg_busy !== 1'b1 || ren !== 1'b1 || wen !== 1'b0) begin failures++; $display("FAIL sim_dbg_wait dbg_busy=%b ren=%b wen=%b required 1/1/0", dbg_busy, ren, wen); end
      tick();
      busy = 0; #1;
      checks++; if (cpu_busy !== 1'b0 || dbg_busy !== 1'b1) begin failures++; $display("FAIL sim_cpu_done cpu_busy=%b dbg_busy=%b required 0/1", cpu_busy, dbg_busy); end
      tick();
      cpu_ren = 0; #1;
      checks++; if (grant_cpu !== 1'b0 || grant_dbg !== 1'b0 || dbg_busy !== 1'b1) begin failures++; $display("FAIL sim_bubble cpu=%b dbg=%b dbg_busy=%b required 0/0/1", grant_cpu, grant_dbg, dbg_busy); end
      checks++; if (dut.starve_cnt !== 4'd1) begin failures++; $display("FAIL sim_starve got %0d required 1", dut.starve_cnt); end
      tick();
      checks++; if (grant_dbg !== 1'b1 || wen !== 1'b1 || ren !== 1'b0) begin failures++; $display("FAIL sim_dbg_grant g=%b wen=%b ren=%b required 1/1/0", grant_dbg, wen, ren); end
      checks++; if (addr !== 32'h0000_0100 || wdata !== 32'h1234_5678 || byte_en !== 4'h3) begin failures++; $display("FAIL sim_dbg_bus addr=%h wdata=%h be=%h required 100/12345678/3", addr, wdata, byte_en); end
      checks++; if (dbg_busy !== 1'b0 || dut.starve_cnt !== 4'd0) begin failures++; $display("FAIL sim_dbg_done dbg_busy=%b starve=%0d required 0/0", dbg_busy, dut.starve_cnt); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_starvation(input logic lock);
      int completions = 0;
      bit got_dbg = 0;
      cpu_ren = 1; cpu_lock = lock; dbg_ren = 1; busy = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (grant_dbg) begin got_dbg = 1; break; end
         if (grant_cpu && !cpu_busy) completions++;
      end
      checks++; if (!got_dbg) begin failures++; $display("FAIL starve_timeout lock=%b no debug grant within 40 cycles", lock); end
      checks++; if (completions != 4) begin failures++; $display("FAIL starve_count lock=%b got %0d required 4", lock, completions); end
      checks++; if (dut.starve_cnt !== 4'd0 || grant_cpu !== 1'b0) begin failures++; $display("FAIL starve_clear lock=%b starve=%0d gcpu=%b required 0/0", lock, dut.starve_cnt, grant_cpu); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_locked_dbg();
      dbg_ren = 1; dbg_lock = 1; dbg_addr = 32'h0; busy = 0;
      tick();
      cpu_ren = 1; #1;
      checks++; if (grant_dbg !== 1'b1 || addr !== 32'h0 || cpu_busy !== 1'b1) begin failures++; $display("FAIL lock_b0 g=%b addr=%h cpu_busy=%b required 1/0/1", grant_dbg, addr, cpu_busy); end
      tick();
      dbg_addr = 32'h4; #1;
      checks++; if (grant_dbg !== 1'b1 || ren !== 1'b1 || addr !== 32'h4) begin failures++; $display("FAIL lock_b1 g=%b ren=%b addr=%h required 1/1/4", grant_dbg, ren, addr); end
      tick();
      dbg_addr = 32'h8; dbg_lock = 0; #1;
      checks++; if (grant_dbg !== 1'b1 || addr !== 32'h8 || dbg_busy !== 1'b0) begin failures++; $display("FAIL lock_b2 g=%b addr=%h dbg_busy=%b required 1/8/0", grant_dbg, addr, dbg_busy); end
      tick();
      dbg_ren = 0; #1;
      checks++; if (grant_dbg !== 1'b0 || grant_cpu !== 1'b0) begin failures++; $display("FAIL lock_release dbg=%b cpu=%b required 0/0", grant_dbg, grant_cpu); end
      tick();
      checks++; if (grant_cpu !== 1'b1) begin failures++; $display("FAIL lock_cpu_after got %b required 1", grant_cpu); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_abort_dual();
      cpu_ren = 1; dbg_ren = 1; busy = 0;
      tick();
      tick();
      busy = 1;
      tick();
      checks++; if (grant_cpu !== 1'b1 || dut.starve_cnt !== 4'd1) begin failures++; $display("FAIL abort_setup g=%b starve=%0d required 1/1", grant_cpu, dut.starve_cnt); end
      cpu_ren = 0; #1;
      checks++; if (cpu_busy !== 1'b0 || ren !== 1'b0) begin failures++; $display("FAIL abort_drop cpu_busy=%b ren=%b required 0/0", cpu_busy, ren); end
      tick();
      checks++; if (grant_cpu !== 1'b0 || dut.starve_cnt !== 4'd1) begin failures++; $display("FAIL abort_cpu_idle g=%b starve=%0d required 0/1", grant_cpu, dut.starve_cnt); end
      tick();
      checks++; if (grant_dbg !== 1'b1) begin failures++; $display("FAIL abort_dbg_grant got %b required 1", grant_dbg); end
      dbg_ren = 0;
      tick();
      checks++; if (grant_dbg !== 1'b0) begin failures++; $display("FAIL abort_dbg_idle got %b required 0", grant_dbg); end
      busy = 0; cpu_ren = 1; cpu_wen = 1; cpu_wdata = 32'hCAFE_F00D;
      tick();
      checks++; if (wen !== 1'b1 || ren !== 1'b0 || wdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL dual_rw wen=%b ren=%b wdata=%h required 1/0/cafef00d", wen, ren, wdata); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      cpu_ren = 1; busy = 1;
      tick();
      checks++; if (grant_cpu !== 1'b1 || ren !== 1'b1) begin failures++; $display("FAIL rst_mid_setup g=%b ren=%b required 1/1", grant_cpu, ren); end
      TRST = 1'b0; #1;
      checks++; if (ren !== 1'b0 || wen !== 1'b0 || grant_cpu !== 1'b0) begin failures++; $display("FAIL rst_mid_async ren=%b wen=%b g=%b required 0/0/0", ren, wen, grant_cpu); end
      TRST = 1'b1;
      tick();
      checks++; if (grant_cpu !== 1'b1 || ren !== 1'b1) begin failures++; $display("FAIL rst_mid_regrant g=%b ren=%b required 1/1", grant_cpu, ren); end
      clear_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_simultaneous();
      test_starvation(1'b0);
      test_starvation(1'b1);
      test_locked_dbg();
      test_abort_dual();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
